// File: rtl/uart_io_pkg.sv
// Shared constants for the memory-mapped UART: register map, STATUS layout,
// transmitter state encoding and the baud divider calculation.
package uart_io_pkg;

  // Register select (single address bit)
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS word bit positions; count occupies [ST_COUNT +: 4]
  localparam int ST_ACTIVE = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_COUNT  = 4;

  // Transmitter FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Clock cycles per bit, truncated
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_io_sync_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == FULL_CNT);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; the head is read out before being overwritten on push+pop when full
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a STATUS register.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | start bit (low) for DIV cycles
//   S_DATA  | eight data bits, LSB first, DIV cycles each
//   S_STOP  | stop bit (high); chains straight into the next frame
module uart_tx_io
  import uart_io_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_io_write,
  input  logic        i_io_read,
  input  logic        i_io_addr,
  input  logic [7:0]  i_io_wdata,
  output logic [31:0] o_io_rdata,
  output logic        o_tx,
  output logic        o_tx_busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ovf;

  logic          w_baud_end;
  logic          w_pop;
  logic          w_frame_active;
  logic          w_line;
  logic          w_data_wr;
  logic          w_stat_wr;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [3:0]    w_count4;
  logic [31:0]   w_status;

  assign w_data_wr  = i_io_write && (i_io_addr == REG_DATA);
  assign w_stat_wr  = i_io_write && (i_io_addr == REG_STATUS);
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_data_wr),
    .i_pop   (w_pop),
    .i_din   (i_io_wdata),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_baud_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_end && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_end) w_state_nxt = w_empty ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop strobe and the line level for the next cycle
  always_comb begin
    w_pop          = 1'b0;
    w_line         = 1'b1;
    w_frame_active = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  w_pop  = !w_empty;
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[0];
      S_STOP:  w_pop  = w_baud_end && !w_empty;
      default: w_pop  = 1'b0;
    endcase
  end

  // Bit timing, shift register and registered line driver
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
    end else begin
      r_tx <= w_line;
      if (w_pop) begin
        r_shift    <= w_head;
        r_bit_cnt  <= '0;
        r_baud_cnt <= '0;
      end else if (w_frame_active) begin
        if (w_baud_end) begin
          r_baud_cnt <= '0;
          if (r_state == S_DATA) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + BW'(1);
        end
      end
    end
  end

  // A dropped byte sets the sticky flag; a set outranks a clear in the same cycle.
  // The clear bit in a STATUS write sits at the same position as the flag it clears.
  assign w_ovf_set = w_data_wr && w_full && !w_pop;
  assign w_ovf_clr = w_stat_wr && i_io_wdata[ST_OVF];

  // Sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // A 16-deep full FIFO reads back count 0; the full bit disambiguates
  assign w_count4 = 4'(w_count);

  // STATUS word assembly and read mux
  always_comb begin
    w_status                 = '0;
    w_status[ST_ACTIVE]      = w_frame_active;
    w_status[ST_FULL]        = w_full;
    w_status[ST_EMPTY]       = w_empty;
    w_status[ST_OVF]         = r_ovf;
    w_status[ST_COUNT +: 4]  = w_count4;
    o_io_rdata               = '0;
    if (i_io_read && (i_io_addr == REG_STATUS)) o_io_rdata = w_status;
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = w_frame_active || !w_empty;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: frame-level reference model checked every cycle,
// plus directed stimulus with literal expectations.
module tb_uart_tx_io;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 8;
  localparam int DIV    = 16;
  localparam int FRAME  = 10 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_io_write = 1'b0;
  logic        i_io_read = 1'b0;
  logic        i_io_addr = 1'b0;
  logic [7:0]  i_io_wdata = 8'h00;
  logic [31:0] o_io_rdata;
  logic        o_tx;
  logic        o_tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_io #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_io_write (i_io_write),
    .i_io_read  (i_io_read),
    .i_io_addr  (i_io_addr),
    .i_io_wdata (i_io_wdata),
    .o_io_rdata (o_io_rdata),
    .o_tx       (o_tx),
    .o_tx_busy  (o_tx_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  logic       m_tx = 1'b1;
  bit         m_valid = 1'b0;
  logic       m_line;
  bit         m_pop;

  // Line level at position t of a frame carrying byte b: start, 8 data LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    s = '0;
    n = m_q.size();
    s[7:4] = n[3:0];
    s[3] = m_ovf;
    s[2] = (n == 0);
    s[1] = (n == DEPTH);
    s[0] = m_active;
    return s;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_t = 0;
      m_ovf = 1'b0;
      m_tx = 1'b1;
      m_valid = 1'b1;
    end else begin
      m_line = m_active ? frame_bit(m_cur, m_t) : 1'b1;
      m_pop = (m_q.size() != 0) && (!m_active || m_t == FRAME - 1);
      if (m_active && m_t != FRAME - 1) begin
        m_t++;
      end else if (m_pop) begin
        m_cur = m_q.pop_front();
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_active = 1'b0;
      end
      if (i_io_write && i_io_addr == 1'b0) begin
        if (m_q.size() < DEPTH) m_q.push_back(i_io_wdata);
        else m_ovf = 1'b1;
      end else if (i_io_write && i_io_addr == 1'b1 && i_io_wdata[3]) begin
        m_ovf = 1'b0;
      end
      m_tx = m_line;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (m_valid) begin
      chk("tx", {31'b0, o_tx}, {31'b0, m_tx});
      chk("busy", {31'b0, o_tx_busy}, {31'b0, (m_active || m_q.size() != 0)});
      chk("rdata", o_io_rdata, (i_io_read && i_io_addr == 1'b1) ? m_status() : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic a, input logic [7:0] d);
    i_io_write = 1'b1;
    i_io_addr  = a;
    i_io_wdata = d;
    @(posedge clock);
    #1;
    i_io_write = 1'b0;
    i_io_addr  = 1'b0;
    i_io_wdata = 8'h00;
  endtask

  task automatic rd_check(input string name, input logic a, input logic [31:0] exp);
    i_io_read = 1'b1;
    i_io_addr = a;
    #2;
    chk(name, o_io_rdata, exp);
    i_io_read = 1'b0;
    i_io_addr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int i;
    i = 0;
    while (o_tx_busy && i < max) begin
      step(1);
      i++;
    end
    chk(name, {31'b0, o_tx_busy}, 32'h0);
  endtask

  int a5_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    rd_check("rst_status", 1'b1, 32'h0000_0004);
    chk("rst_tx", {31'b0, o_tx}, 32'h1);
    chk("rst_busy", {31'b0, o_tx_busy}, 32'h0);

    // Single byte A5
    do_write(1'b0, 8'hA5);
    rd_check("a5_queued", 1'b1, 32'h0000_0010);
    step(1);
    chk("a5_tx_n1", {31'b0, o_tx}, 32'h1);
    rd_check("a5_started", 1'b1, 32'h0000_0005);
    step(1);
    chk("a5_tx_fall", {31'b0, o_tx}, 32'h0);
    step(8);
    chk("a5_bit0", {31'b0, o_tx}, a5_exp[0]);
    for (int k = 1; k <= 9; k++) begin
      step(16);
      chk($sformatf("a5_bit%0d", k), {31'b0, o_tx}, a5_exp[k]);
    end
    step(8);
    chk("a5_busy_done", {31'b0, o_tx_busy}, 32'h0);
    chk("a5_tx_idle", {31'b0, o_tx}, 32'h1);

    // Burst behind an active frame so the FIFO fills
    do_write(1'b0, 8'h5A);
    for (int b = 0; b < 8; b++) do_write(1'b0, 8'(b));
    rd_check("burst_full", 1'b1, 32'h0000_0083);
    do_write(1'b0, 8'hFF);
    rd_check("ovf_set", 1'b1, 32'h0000_008B);
    do_write(1'b1, 8'h08);
    rd_check("ovf_clr", 1'b1, 32'h0000_0083);
    // Write lands on the stop-bit pop edge of the 5A frame
    step(150);
    rd_check("pre_pushpop", 1'b1, 32'h0000_0083);
    do_write(1'b0, 8'h77);
    rd_check("pushpop", 1'b1, 32'h0000_0083);
    i_io_read = 1'b1;
    i_io_addr = 1'b1;
    wait_idle("burst_drain", 2000);
    i_io_read = 1'b0;
    i_io_addr = 1'b0;
    rd_check("drain_status", 1'b1, 32'h0000_0004);

    // Read mux
    do_write(1'b0, 8'h11);
    do_write(1'b0, 8'h22);
    do_write(1'b0, 8'h33);
    do_write(1'b0, 8'h44);
    rd_check("rd_status3", 1'b1, 32'h0000_0031);
    rd_check("rd_data", 1'b0, 32'h0);
    i_io_addr = 1'b1;
    #1;
    chk("rd_noread", o_io_rdata, 32'h0);
    i_io_addr = 1'b0;
    wait_idle("mux_drain", 1000);

    // Reset mid-frame during bit 3 of 3C with another byte queued
    do_write(1'b0, 8'h3C);
    do_write(1'b0, 8'hC3);
    step(25);
    chk("3c_bit0", {31'b0, o_tx}, 32'h0);
    step(46);
    chk("3c_bit3", {31'b0, o_tx}, 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_mid_tx", {31'b0, o_tx}, 32'h1);
    chk("rst_mid_busy", {31'b0, o_tx_busy}, 32'h0);
    rd_check("rst_mid_status", 1'b1, 32'h0000_0004);
    step(200);
    chk("post_rst_tx", {31'b0, o_tx}, 32'h1);
    chk("post_rst_busy", {31'b0, o_tx_busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
